cpu_state_controller: RTL and testbench

- Instruction sequencer for the simple RISC CPU.
- Steps each instruction through fetch (2 bytes), decode and execute phases.
- Drives control strobes for the program counter, instruction register, accumulator, data-bus driver and memory.
- Waits on a memory-ready handshake for every memory access, and holds in a halt state until resumed.

---
 rtl/cpu_state_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_cpu_state_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_state_controller.sv
// ----------------------------------------------------------------------------
// cpu_state_controller
//
// Instruction sequencer for the simple RISC CPU. Each instruction is fetched
// as two bytes (F1, F2), decoded (DEC), then executed in one or more execute
// cycles (EX1, EX2). Every memory access waits on mem_ready. HLT parks the
// sequencer in HALT until resume is seen.
//
// Parameters:
//   SKIP_LEN     PC increments issued by a taken SKZ (length in bytes of the
//                skipped instruction); legal range 1..4
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   ena          run enable, sampled when an instruction finishes (and in IDLE)
//   opcode       IR[15:13], captured into op_q when leaving DEC
//   zero         accumulator == 0, consulted only in EX1 of SKZ
//   mem_ready    memory completes the current rd/wr in this cycle
//   resume       leave HALT (ignored in every other state)
//   inc_pc       PC increment strobe
//   load_pc      PC load from IR address field (JMP)
//   load_ir      IR byte capture enable
//   load_acc     accumulator load enable
//   rd           memory read request
//   wr           memory write request
//   datactl_ena  drive the accumulator onto the data bus
//   halt         CPU halted indicator
//   state        current state encoding, for debug
//
// All outputs are decoded combinationally from state, op_q, zero and
// mem_ready; there are no output registers.
// ----------------------------------------------------------------------------
module cpu_state_controller #(
    parameter int SKIP_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       resume,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_acc,
    output logic       rd,
    output logic       wr,
    output logic       datactl_ena,
    output logic       halt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        F1   = 3'd1,
        F2   = 3'd2,
        DEC  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        HALT = 3'd6
    } state_t;

    localparam logic [2:0] OP_HLT  = 3'b000;
    localparam logic [2:0] OP_SKZ  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ANDD = 3'b011;
    localparam logic [2:0] OP_XORR = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_STO  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    // Value of skip_cnt+1 on the last increment of a taken SKZ.
    localparam logic [2:0] SKIP_LAST = 3'(SKIP_LEN);

    state_t     state_q;
    state_t     state_d;
    state_t     next_instr;
    logic [2:0] op_q;
    logic [2:0] skip_cnt_q;
    logic [2:0] skip_cnt_d;
    logic [2:0] skip_cnt_inc;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            skip_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    // The opcode is held for the whole execute phase, so later changes of
    // the IR (or of the opcode input) cannot disturb EX1/EX2 decoding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= OP_HLT;
        end else if (state_q == DEC) begin
            op_q <= opcode;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statements can leave one unassigned (no latch).
        state_d      = state_q;
        skip_cnt_d   = skip_cnt_q;
        inc_pc       = 1'b0;
        load_pc      = 1'b0;
        load_ir      = 1'b0;
        load_acc     = 1'b0;
        rd           = 1'b0;
        wr           = 1'b0;
        datactl_ena  = 1'b0;
        halt         = 1'b0;
        skip_cnt_inc = skip_cnt_q + 3'd1;

        // Where an instruction goes once it is done: straight into the next
        // fetch while enabled, otherwise park in IDLE.
        next_instr = ena ? F1 : IDLE;

        case (state_q)
            IDLE: begin
                if (ena) state_d = F1;
            end

            // Both fetch cycles hold rd/load_ir steady while memory stalls;
            // the PC only advances on the cycle the byte actually arrives.
            F1: begin
                rd      = 1'b1;
                load_ir = 1'b1;
                inc_pc  = mem_ready;
                if (mem_ready) state_d = F2;
            end

            F2: begin
                rd      = 1'b1;
                load_ir = 1'b1;
                inc_pc  = mem_ready;
                if (mem_ready) state_d = DEC;
            end

            DEC: begin
                skip_cnt_d = 3'd0;
                state_d    = (opcode == OP_HLT) ? HALT : EX1;
            end

            EX1: begin
                case (op_q)
                    OP_ADD, OP_ANDD, OP_XORR, OP_LDA: begin
                        rd       = 1'b1;
                        load_acc = mem_ready;
                        if (mem_ready) state_d = next_instr;
                    end
                    // Bus setup cycle: the accumulator is on the bus one
                    // cycle before wr is raised.
                    OP_STO: begin
                        datactl_ena = 1'b1;
                        state_d     = EX2;
                    end
                    OP_JMP: begin
                        load_pc = 1'b1;
                        state_d = next_instr;
                    end
                    OP_SKZ: begin
                        if (zero) begin
                            inc_pc     = 1'b1;
                            skip_cnt_d = 3'd1;
                            state_d    = (SKIP_LEN == 1) ? next_instr : EX2;
                        end else begin
                            state_d = next_instr;
                        end
                    end
                    default: begin
                        // HLT never reaches EX1; recover quietly.
                        state_d = IDLE;
                    end
                endcase
            end

            EX2: begin
                case (op_q)
                    OP_STO: begin
                        datactl_ena = 1'b1;
                        wr          = 1'b1;
                        if (mem_ready) state_d = next_instr;
                    end
                    // Remaining increments of a taken skip; EX1 issued the
                    // first one, so this ends when the count reaches SKIP_LEN.
                    OP_SKZ: begin
                        inc_pc     = 1'b1;
                        skip_cnt_d = skip_cnt_inc;
                        if (skip_cnt_inc == SKIP_LAST) state_d = next_instr;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end

            HALT: begin
                halt = 1'b1;
                if (resume) state_d = next_instr;
            end

            // Unused encoding 7: all outputs stay 0, fall back to IDLE.
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_cpu_state_controller.sv
// ----------------------------------------------------------------------------
// tb_cpu_state_controller
//
// Bench for cpu_state_controller. A reference model describes each
// instruction as a queue of micro-operations (fetch bytes, decode, execute
// steps) and predicts every output from the head of that queue; one compare
// process checks the DUT against it on every falling clock edge. A directed
// sequence with literal per-cycle expectations pins the model, followed by a
// randomized run.
// ----------------------------------------------------------------------------
module tb_cpu_state_controller;

    localparam int SKIP_LEN = 2;

    // Output vector order: inc_pc, load_pc, load_ir, load_acc, rd, wr,
    // datactl_ena, halt.
    localparam logic [7:0] O_NONE  = 8'b0000_0000;
    localparam logic [7:0] O_FETCH = 8'b1010_1000;
    localparam logic [7:0] O_STALL = 8'b0010_1000;
    localparam logic [7:0] O_ALU   = 8'b0001_1000;
    localparam logic [7:0] O_SETUP = 8'b0000_0010;
    localparam logic [7:0] O_WRITE = 8'b0000_0110;
    localparam logic [7:0] O_INC   = 8'b1000_0000;
    localparam logic [7:0] O_JUMP  = 8'b0100_0000;
    localparam logic [7:0] O_HALT  = 8'b0000_0001;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       resume;
    logic       inc_pc;
    logic       load_pc;
    logic       load_ir;
    logic       load_acc;
    logic       rd;
    logic       wr;
    logic       datactl_ena;
    logic       halt;
    logic [2:0] state;

    logic [7:0] dut_out;
    assign dut_out = {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt};

    int n_checks = 0;
    int n_pass   = 0;

    cpu_state_controller #(.SKIP_LEN(SKIP_LEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .resume      (resume),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .load_ir     (load_ir),
        .load_acc    (load_acc),
        .rd          (rd),
        .wr          (wr),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an instruction is a queue of micro-operations.
    // ------------------------------------------------------------------
    typedef enum {
        U_FETCH_HI, U_FETCH_LO, U_DECODE, U_ALU_READ, U_STO_SETUP,
        U_STO_WRITE, U_JUMP, U_SKZ_TEST, U_SKZ_INC, U_HALTED
    } uop_e;

    uop_e uq[$];

    always @(negedge clk) begin
        logic [7:0] exp_out;
        logic [2:0] exp_state;
        logic       done;
        uop_e       head;

        if (rst) begin
            uq.delete();
            check("reset_outputs", {5'd0, state, dut_out}, {5'd0, 3'd0, O_NONE});
        end else begin
            exp_out   = O_NONE;
            exp_state = 3'd0;
            done      = 1'b0;
            if (uq.size() != 0) begin
                case (uq[0])
                    U_FETCH_HI:  begin exp_state = 3'd1; exp_out = mem_ready ? O_FETCH : O_STALL; done = mem_ready; end
                    U_FETCH_LO:  begin exp_state = 3'd2; exp_out = mem_ready ? O_FETCH : O_STALL; done = mem_ready; end
                    U_DECODE:    begin exp_state = 3'd3; done = 1'b1; end
                    U_ALU_READ:  begin exp_state = 3'd4; exp_out = mem_ready ? O_ALU : 8'b0000_1000; done = mem_ready; end
                    U_STO_SETUP: begin exp_state = 3'd4; exp_out = O_SETUP; done = 1'b1; end
                    U_STO_WRITE: begin exp_state = 3'd5; exp_out = O_WRITE; done = mem_ready; end
                    U_JUMP:      begin exp_state = 3'd4; exp_out = O_JUMP; done = 1'b1; end
                    U_SKZ_TEST:  begin exp_state = 3'd4; exp_out = zero ? O_INC : O_NONE; done = 1'b1; end
                    U_SKZ_INC:   begin exp_state = 3'd5; exp_out = O_INC; done = 1'b1; end
                    U_HALTED:    begin exp_state = 3'd6; exp_out = O_HALT; done = resume; end
                    default:     ;
                endcase
            end
            check("outputs_vs_model", {5'd0, state, dut_out}, {5'd0, exp_state, exp_out});

            // Advance the model using the inputs the DUT samples at the next edge.
            if (uq.size() == 0) begin
                if (ena) uq = '{U_FETCH_HI, U_FETCH_LO, U_DECODE};
            end else if (done) begin
                head = uq.pop_front();
                if (head == U_DECODE) begin
                    case (opcode)
                        3'b000:                         uq.push_back(U_HALTED);
                        3'b001:                         uq.push_back(U_SKZ_TEST);
                        3'b010, 3'b011, 3'b100, 3'b101: uq.push_back(U_ALU_READ);
                        3'b110: begin uq.push_back(U_STO_SETUP); uq.push_back(U_STO_WRITE); end
                        default:                        uq.push_back(U_JUMP);
                    endcase
                end
                if (head == U_SKZ_TEST && zero) begin
                    for (int k = 1; k < SKIP_LEN; k++) uq.push_back(U_SKZ_INC);
                end
                if (uq.size() == 0 && ena) uq = '{U_FETCH_HI, U_FETCH_LO, U_DECODE};
            end
        end
    end

    // One clock cycle with literal expectations: check at the falling edge,
    // then return just after the next rising edge so inputs can be changed.
    task automatic expect_cycle(input string name, input logic [2:0] exp_state, input logic [7:0] exp_out);
        @(negedge clk);
        check(name, {5'd0, state, dut_out}, {5'd0, exp_state, exp_out});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        ena       = 1'b0;
        opcode    = 3'b000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        resume    = 1'b0;

        // Reset and idle with ena low.
        expect_cycle("lit_reset", 3'd0, O_NONE);
        rst = 1'b0;
        repeat (3) expect_cycle("lit_idle", 3'd0, O_NONE);

        // ADD with memory always ready: 1,2,3,4 then the next fetch.
        ena = 1'b1; opcode = 3'b010; mem_ready = 1'b1;
        expect_cycle("lit_idle_ena", 3'd0, O_NONE);
        expect_cycle("lit_add_f1",  3'd1, O_FETCH);
        expect_cycle("lit_add_f2",  3'd2, O_FETCH);
        expect_cycle("lit_add_dec", 3'd3, O_NONE);
        expect_cycle("lit_add_ex1", 3'd4, O_ALU);

        // STO with three wait cycles in the write.
        opcode = 3'b110;
        expect_cycle("lit_sto_f1",  3'd1, O_FETCH);
        expect_cycle("lit_sto_f2",  3'd2, O_FETCH);
        expect_cycle("lit_sto_dec", 3'd3, O_NONE);
        expect_cycle("lit_sto_ex1", 3'd4, O_SETUP);
        mem_ready = 1'b0;
        repeat (3) expect_cycle("lit_sto_wait", 3'd5, O_WRITE);
        mem_ready = 1'b1;
        expect_cycle("lit_sto_done", 3'd5, O_WRITE);

        // SKZ taken: SKIP_LEN increments across EX1 and EX2.
        opcode = 3'b001; zero = 1'b1;
        expect_cycle("lit_skz_f1",  3'd1, O_FETCH);
        expect_cycle("lit_skz_f2",  3'd2, O_FETCH);
        expect_cycle("lit_skz_dec", 3'd3, O_NONE);
        expect_cycle("lit_skz_ex1", 3'd4, O_INC);
        expect_cycle("lit_skz_ex2", 3'd5, O_INC);

        // SKZ not taken: EX1 only, no increment.
        zero = 1'b0;
        expect_cycle("lit_skzn_f1",  3'd1, O_FETCH);
        expect_cycle("lit_skzn_f2",  3'd2, O_FETCH);
        expect_cycle("lit_skzn_dec", 3'd3, O_NONE);
        expect_cycle("lit_skzn_ex1", 3'd4, O_NONE);

        // JMP: one load_pc cycle.
        opcode = 3'b111;
        expect_cycle("lit_jmp_f1",  3'd1, O_FETCH);
        expect_cycle("lit_jmp_f2",  3'd2, O_FETCH);
        expect_cycle("lit_jmp_dec", 3'd3, O_NONE);
        expect_cycle("lit_jmp_ex1", 3'd4, O_JUMP);

        // HLT, with a resume pulse in a stalled F1 that must be ignored.
        opcode = 3'b000; mem_ready = 1'b0; resume = 1'b1;
        expect_cycle("lit_hlt_f1_resume", 3'd1, O_STALL);
        mem_ready = 1'b1; resume = 1'b0;
        expect_cycle("lit_hlt_f1",  3'd1, O_FETCH);
        expect_cycle("lit_hlt_f2",  3'd2, O_FETCH);
        expect_cycle("lit_hlt_dec", 3'd3, O_NONE);
        repeat (10) expect_cycle("lit_halted", 3'd6, O_HALT);
        resume = 1'b1;
        expect_cycle("lit_halt_resume", 3'd6, O_HALT);
        resume = 1'b0;
        expect_cycle("lit_after_halt", 3'd1, O_FETCH);

        // Asynchronous reset in the middle of F2.
        #1;
        check("lit_mid_f2_state", {29'd0, state}, 32'd2);
        check("lit_mid_f2_rd", {31'd0, rd}, 32'd1);
        rst = 1'b1;
        #1;
        check("lit_async_reset", {5'd0, state, dut_out}, {5'd0, 3'd0, O_NONE});
        @(posedge clk);
        #1;
        rst = 1'b0; ena = 1'b0;
        repeat (2) expect_cycle("lit_idle_after_reset", 3'd0, O_NONE);

        // Randomized run, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            ena       = ($urandom_range(0, 9) != 0);
            opcode    = 3'($urandom_range(0, 7));
            zero      = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 9) < 7);
            resume    = ($urandom_range(0, 4) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
